// File: rtl/backprop_sched_pkg.sv
`default_nettype none
// ============================================================================
// backprop_sched_pkg : shared FSM states and control-word layout
// Revision: 1.0
// ============================================================================
package backprop_sched_pkg;

    localparam int c_bpc_size   = 66;
    localparam int c_neuron_lsb = 0;
    localparam int c_layer_lsb  = 32;
    localparam int c_first_bit  = 64;
    localparam int c_output_bit = 65;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_issue  = 2'd1;
    localparam state_t c_st_drain  = 2'd2;
    localparam state_t c_st_finish = 2'd3;

    function automatic logic [c_bpc_size-1:0] pack_ctrl(
        input logic        output_layer,
        input logic        first_layer,
        input logic [31:0] layer_idx,
        input logic [31:0] neuron_idx
    );
        logic [c_bpc_size-1:0] w;
        w                             = '0;
        w[c_output_bit]               = output_layer;
        w[c_first_bit]                = first_layer;
        w[c_layer_lsb  +: 32]         = layer_idx;
        w[c_neuron_lsb +: 32]         = neuron_idx;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/backprop_sched_outstanding_cnt.sv
`default_nettype none
// ============================================================================
// outstanding_cnt : beats in flight; decrements at zero are refused and flagged
// Revision: 1.0
// ============================================================================
module outstanding_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             underflow
);

    logic w_dec_ok;

    assign w_dec_ok  = dec && (count != '0);
    assign underflow = dec && (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({inc, w_dec_ok})
                2'b10:   count <= count + WIDTH'(1);
                2'b01:   count <= count - WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/backprop_sched.sv
`default_nettype none
// ============================================================================
// backprop_sched : issues per-neuron control beats layer by layer, top down
// Revision: 1.0
// ============================================================================
module backprop_sched
    import backprop_sched_pkg::*;
#(
    parameter int size                   = 3,
    parameter int backprop_controll_size = c_bpc_size,
    parameter int learning_rate_size     = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [31:0]                       layer_count,
    input  logic [learning_rate_size-1:0]     learning_rate,
    input  logic                              issue_ready,
    input  logic                              result_valid,
    output logic                              issue_valid,
    output logic [backprop_controll_size-1:0] backprop_controll,
    output logic [learning_rate_size-1:0]     learning_rate_out,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int          c_cnt_w       = $clog2(size + 1);
    localparam logic [31:0] c_last_neuron = 32'(size - 1);

    state_t                        r_state;
    logic [31:0]                   r_layer_count;
    logic [31:0]                   r_layer_idx;
    logic [31:0]                   r_neuron_idx;
    logic [learning_rate_size-1:0] r_lr;
    logic                          r_err;

    logic                          w_xfer;
    logic                          w_underflow;
    logic [c_cnt_w-1:0]            w_outstanding;
    logic [c_bpc_size-1:0]         w_word;

    // Valid is qualified by ready so a stalled beat is never seen as presented.
    assign issue_valid = (r_state == c_st_issue) && issue_ready;
    assign w_xfer      = issue_valid && issue_ready;

    assign w_word = pack_ctrl(r_layer_idx == (r_layer_count - 32'd1),
                              r_layer_idx == 32'd0,
                              r_layer_idx,
                              r_neuron_idx);

    assign backprop_controll = (r_state == c_st_issue) ? backprop_controll_size'(w_word)
                                                       : '0;
    assign learning_rate_out = r_lr;
    assign busy              = (r_state != c_st_idle);
    assign done              = (r_state == c_st_finish);
    assign err               = r_err;

    outstanding_cnt #(
        .WIDTH (c_cnt_w)
    ) u_outstanding_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_xfer),
        .dec       (result_valid),
        .count     (w_outstanding),
        .underflow (w_underflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_layer_count <= '0;
            r_layer_idx   <= '0;
            r_neuron_idx  <= '0;
            r_lr          <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_err         <= 1'b0;
                        r_lr          <= learning_rate;
                        r_layer_count <= layer_count;
                        r_neuron_idx  <= '0;
                        if (layer_count != 32'd0) begin
                            r_layer_idx <= layer_count - 32'd1;
                            r_state     <= c_st_issue;
                        end else begin
                            r_layer_idx <= '0;
                            r_err       <= 1'b1;
                            r_state     <= c_st_finish;
                        end
                    end
                end
                c_st_issue: begin
                    if (w_xfer) begin
                        if (r_neuron_idx == c_last_neuron) begin
                            r_neuron_idx <= '0;
                            r_state      <= c_st_drain;
                        end else begin
                            r_neuron_idx <= r_neuron_idx + 32'd1;
                        end
                    end
                end
                c_st_drain: begin
                    // A layer is only left once every one of its beats has retired.
                    if (w_outstanding == '0) begin
                        if (r_layer_idx != 32'd0) begin
                            r_layer_idx <= r_layer_idx - 32'd1;
                            r_state     <= c_st_issue;
                        end else begin
                            r_state     <= c_st_finish;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            // Stray results win over the clear from a same-cycle start.
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
